// File: rtl/fpnew_issue_rob_pkg.sv
// Shared types for the FPU issue/reorder companion block.
//
// Contents:
//   roundmode_e, operation_e, fp_format_e, int_format_e, status_t
//     - the FPU op-field and flag types forwarded by the issue path
//   FLEN        - operand/result width stored per ROB entry
//   rob_entry_t - one reorder-buffer slot (result + status flags)
//   tag_width() - tag width for a given depth, never less than 1 bit
package fpnew_issue_rob_pkg;

   localparam int unsigned FLEN = 64;

   typedef enum logic [2:0] {
      RNE = 3'b000,
      RTZ = 3'b001,
      RDN = 3'b010,
      RUP = 3'b011,
      RMM = 3'b100,
      DYN = 3'b111
   } roundmode_e;

   typedef enum logic [3:0] {
      FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX,
      CMP, CLASSIFY, F2F, F2I, I2F, CPKAB, CPKCD
   } operation_e;

   typedef enum logic [2:0] {
      FP32, FP64, FP16, FP8, FP16ALT
   } fp_format_e;

   typedef enum logic [1:0] {
      INT8, INT16, INT32, INT64
   } int_format_e;

   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } status_t;

   typedef struct packed {
      logic [FLEN-1:0] result;
      status_t         status;
   } rob_entry_t;

   // $clog2(1) is 0, which would give a zero-width tag bus.
   function automatic int unsigned tag_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fpnew_rob_storage.sv
// Result/status storage for the reorder buffer.
//
// One tag-indexed write port (FPU result return) and one asynchronous read
// port (ROB head). Data carries no reset: validity lives in the done bits
// kept by the parent.
//
// Ports:
//   clk_i   - clock
//   we_i    - write enable
//   waddr_i - slot written (result tag)
//   wdata_i - entry written
//   raddr_i - slot read (head pointer)
//   rdata_o - entry at raddr_i
module fpnew_rob_storage
   import fpnew_issue_rob_pkg::*;
#(
   parameter int unsigned NumEntries = 4,
   parameter int unsigned TagWidth   = 2
) (
   input  logic                clk_i,
   input  logic                we_i,
   input  logic [TagWidth-1:0] waddr_i,
   input  rob_entry_t          wdata_i,
   input  logic [TagWidth-1:0] raddr_i,
   output rob_entry_t          rdata_o
);

   rob_entry_t mem_q [NumEntries];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fpnew_issue_rob.sv
// Requester-side FPU companion: tags ops from the core, issues them to the
// FPU, collects out-of-order results by tag and returns them in issue order.
//
// Optional build macro: FPNEW_ISSUE_ROB_FFLAGS_EN adds fflags_clr_i and
// fflags_o (sticky OR of the status of every retired op).
//
// Ports:
//   clk_i, rst_i                 - clock, synchronous active-high reset
//   req_*                        - core request (valid/ready, operands, op fields)
//   flush_i                      - kill every outstanding op
//   fpu_* outputs                - forwarded op fields, tag, issue valid, flush
//   fpu_in_ready_i               - FPU accepts the issued op
//   fpu_result_i/status_i/tag_i  - FPU result return, fpu_out_valid_i/ready_o
//   rsp_*                        - in-order response to the core
//   busy_o                       - at least one slot allocated
//   err_stray_o                  - sticky: result for a slot not awaiting one
module fpnew_issue_rob
   import fpnew_issue_rob_pkg::*;
#(
   parameter  int unsigned Width      = FLEN,  // must equal FLEN
   parameter  int unsigned NumEntries = 4,     // power of two, 2..16
   localparam int unsigned TagWidth   = tag_width(NumEntries)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [3*Width-1:0]    req_operands_i,
   input  roundmode_e            req_rnd_mode_i,
   input  operation_e            req_op_i,
   input  logic                  req_op_mod_i,
   input  fp_format_e            req_src_fmt_i,
   input  fp_format_e            req_dst_fmt_i,
   input  int_format_e           req_int_fmt_i,
   input  logic                  req_vectorial_op_i,
   input  logic                  flush_i,
   output logic [3*Width-1:0]    fpu_operands_o,
   output roundmode_e            fpu_rnd_mode_o,
   output operation_e            fpu_op_o,
   output logic                  fpu_op_mod_o,
   output fp_format_e            fpu_src_fmt_o,
   output fp_format_e            fpu_dst_fmt_o,
   output int_format_e           fpu_int_fmt_o,
   output logic                  fpu_vectorial_op_o,
   output logic [TagWidth-1:0]   fpu_tag_o,
   output logic                  fpu_in_valid_o,
   input  logic                  fpu_in_ready_i,
   output logic                  fpu_flush_o,
   input  logic [Width-1:0]      fpu_result_i,
   input  status_t               fpu_status_i,
   input  logic [TagWidth-1:0]   fpu_tag_i,
   input  logic                  fpu_out_valid_i,
   output logic                  fpu_out_ready_o,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [Width-1:0]      rsp_result_o,
   output status_t               rsp_status_o,
   output logic                  busy_o,
   output logic                  err_stray_o
`ifdef FPNEW_ISSUE_ROB_FFLAGS_EN
  ,input  logic                  fflags_clr_i,
   output status_t               fflags_o
`endif
);

   localparam int unsigned         CntWidth = TagWidth + 1;
   localparam logic [CntWidth-1:0] CntFull  = CntWidth'(NumEntries);
   localparam logic [CntWidth-1:0] CntOne   = CntWidth'(1);
   localparam logic [TagWidth-1:0] TagOne   = TagWidth'(1);

   logic [TagWidth-1:0]   head_q, tail_q;
   logic [CntWidth-1:0]   count_q;
   logic [NumEntries-1:0] alloc_q, done_q;
   logic                  err_stray_q;

   logic       full, issue, retire, res_ok, res_stray;
   rob_entry_t wr_entry, rd_entry;

   // Issue path: pure pass-through, the FPU handshake is the core handshake.
   assign fpu_operands_o     = req_operands_i;
   assign fpu_rnd_mode_o     = req_rnd_mode_i;
   assign fpu_op_o           = req_op_i;
   assign fpu_op_mod_o       = req_op_mod_i;
   assign fpu_src_fmt_o      = req_src_fmt_i;
   assign fpu_dst_fmt_o      = req_dst_fmt_i;
   assign fpu_int_fmt_o      = req_int_fmt_i;
   assign fpu_vectorial_op_o = req_vectorial_op_i;
   assign fpu_tag_o          = tail_q;
   assign fpu_flush_o        = flush_i;

   // Full uses the registered count, so a same-cycle retire never frees a slot.
   assign full           = (count_q == CntFull);
   assign fpu_in_valid_o = req_valid_i & ~full & ~flush_i;
   assign req_ready_o    = fpu_in_valid_o & fpu_in_ready_i;
   assign issue          = req_ready_o;

   // Every allocated slot already owns its storage, so results never stall.
   assign fpu_out_ready_o = 1'b1;
   assign res_ok    = fpu_out_valid_i & ~flush_i & alloc_q[fpu_tag_i] & ~done_q[fpu_tag_i];
   assign res_stray = fpu_out_valid_i & ~flush_i & ~(alloc_q[fpu_tag_i] & ~done_q[fpu_tag_i]);

   // Storage has no reset; gating on valid keeps the data outputs at 0 when idle.
   assign rsp_valid_o  = done_q[head_q];
   assign rsp_result_o = rsp_valid_o ? rd_entry.result[Width-1:0] : '0;
   assign rsp_status_o = rsp_valid_o ? rd_entry.status : '0;
   assign retire       = rsp_valid_o & rsp_ready_i & ~flush_i;

   assign busy_o      = (count_q != '0);
   assign err_stray_o = err_stray_q;

   assign wr_entry.result = fpu_result_i;
   assign wr_entry.status = fpu_status_i;

   fpnew_rob_storage #(
      .NumEntries (NumEntries),
      .TagWidth   (TagWidth)
   ) u_storage (
      .clk_i   (clk_i),
      .we_i    (res_ok),
      .waddr_i (fpu_tag_i),
      .wdata_i (wr_entry),
      .raddr_i (head_q),
      .rdata_o (rd_entry)
   );

   // The issue slot (tail, unallocated), the written slot (allocated, not done)
   // and the retiring slot (head, done) are always distinct, so the per-bit
   // updates below never collide.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         alloc_q     <= '0;
         done_q      <= '0;
         err_stray_q <= 1'b0;
      end else if (flush_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         alloc_q <= '0;
         done_q  <= '0;
      end else begin
         if (issue) begin
            alloc_q[tail_q] <= 1'b1;
            done_q[tail_q]  <= 1'b0;
            tail_q          <= tail_q + TagOne;
         end
         if (res_ok) done_q[fpu_tag_i] <= 1'b1;
         if (res_stray) err_stray_q <= 1'b1;
         if (retire) begin
            alloc_q[head_q] <= 1'b0;
            done_q[head_q]  <= 1'b0;
            head_q          <= head_q + TagOne;
         end
         case ({issue, retire})
            2'b10:   count_q <= count_q + CntOne;
            2'b01:   count_q <= count_q - CntOne;
            default: count_q <= count_q;
         endcase
      end
   end

`ifdef FPNEW_ISSUE_ROB_FFLAGS_EN
   status_t fflags_q;
   status_t retire_flags;

   assign retire_flags = retire ? rd_entry.status : '0;
   assign fflags_o     = fflags_q;

   // Flush leaves accumulated flags alone; clear still lets the retiring op in.
   always_ff @(posedge clk_i) begin
      if (rst_i)             fflags_q <= '0;
      else if (fflags_clr_i) fflags_q <= retire_flags;
      else                   fflags_q <= fflags_q | retire_flags;
   end
`endif

endmodule

// File: tb/tb_fpnew_issue_rob.sv
module tb_fpnew_issue_rob;
   import fpnew_issue_rob_pkg::*;

   localparam int unsigned W  = 64;
   localparam int unsigned N  = 4;
   localparam int unsigned TW = 2;

   logic             clk;
   logic             rst;
   logic             req_valid, req_ready;
   logic [3*W-1:0]   req_operands;
   roundmode_e       req_rnd_mode;
   operation_e       req_op;
   logic             req_op_mod;
   fp_format_e       req_src_fmt, req_dst_fmt;
   int_format_e      req_int_fmt;
   logic             req_vec;
   logic             flush;
   logic [3*W-1:0]   fpu_operands;
   roundmode_e       fpu_rnd_mode;
   operation_e       fpu_op;
   logic             fpu_op_mod;
   fp_format_e       fpu_src_fmt, fpu_dst_fmt;
   int_format_e      fpu_int_fmt;
   logic             fpu_vec;
   logic [TW-1:0]    fpu_tag_o;
   logic             fpu_in_valid, fpu_in_ready, fpu_flush;
   logic [W-1:0]     fpu_result;
   status_t          fpu_status;
   logic [TW-1:0]    fpu_tag_i;
   logic             fpu_out_valid, fpu_out_ready;
   logic             rsp_valid, rsp_ready;
   logic [W-1:0]     rsp_result;
   status_t          rsp_status;
   logic             busy, err_stray;
`ifdef FPNEW_ISSUE_ROB_FFLAGS_EN
   logic             fflags_clr;
   status_t          fflags;
`endif

   fpnew_issue_rob #(.Width(W), .NumEntries(N)) dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .req_valid_i        (req_valid),
      .req_ready_o        (req_ready),
      .req_operands_i     (req_operands),
      .req_rnd_mode_i     (req_rnd_mode),
      .req_op_i           (req_op),
      .req_op_mod_i       (req_op_mod),
      .req_src_fmt_i      (req_src_fmt),
      .req_dst_fmt_i      (req_dst_fmt),
      .req_int_fmt_i      (req_int_fmt),
      .req_vectorial_op_i (req_vec),
      .flush_i            (flush),
      .fpu_operands_o     (fpu_operands),
      .fpu_rnd_mode_o     (fpu_rnd_mode),
      .fpu_op_o           (fpu_op),
      .fpu_op_mod_o       (fpu_op_mod),
      .fpu_src_fmt_o      (fpu_src_fmt),
      .fpu_dst_fmt_o      (fpu_dst_fmt),
      .fpu_int_fmt_o      (fpu_int_fmt),
      .fpu_vectorial_op_o (fpu_vec),
      .fpu_tag_o          (fpu_tag_o),
      .fpu_in_valid_o     (fpu_in_valid),
      .fpu_in_ready_i     (fpu_in_ready),
      .fpu_flush_o        (fpu_flush),
      .fpu_result_i       (fpu_result),
      .fpu_status_i       (fpu_status),
      .fpu_tag_i          (fpu_tag_i),
      .fpu_out_valid_i    (fpu_out_valid),
      .fpu_out_ready_o    (fpu_out_ready),
      .rsp_valid_o        (rsp_valid),
      .rsp_ready_i        (rsp_ready),
      .rsp_result_o       (rsp_result),
      .rsp_status_o       (rsp_status),
      .busy_o             (busy),
      .err_stray_o        (err_stray)
`ifdef FPNEW_ISSUE_ROB_FFLAGS_EN
     ,.fflags_clr_i       (fflags_clr),
      .fflags_o           (fflags)
`endif
   );

   typedef struct packed {
      logic [W-1:0] result;
      status_t      status;
   } exp_t;

   exp_t         sb_q[$];
   logic [W-1:0] fpu_res [N];
   status_t      fpu_st  [N];
   int           checks   = 0;
   int           failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [W-1:0] fpu_model(input logic [W-1:0] a);
      return (a ^ 64'h5A5A_0000_A5A5_0000) + 64'd3;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid     = 1'b0;
      req_operands  = '0;
      req_rnd_mode  = RNE;
      req_op        = ADD;
      req_op_mod    = 1'b0;
      req_src_fmt   = FP64;
      req_dst_fmt   = FP64;
      req_int_fmt   = INT32;
      req_vec       = 1'b0;
      flush         = 1'b0;
      fpu_in_ready  = 1'b1;
      fpu_result    = '0;
      fpu_status    = '0;
      fpu_tag_i     = '0;
      fpu_out_valid = 1'b0;
      rsp_ready     = 1'b0;
`ifdef FPNEW_ISSUE_ROB_FFLAGS_EN
      fflags_clr    = 1'b0;
`endif
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      repeat (2) tick();
      rst = 1'b0;
      sb_q.delete();
   endtask

   // Issue one op, expecting it to receive exp_tag; records the result the
   // FPU model will return for that tag and pushes it onto the scoreboard.
   task automatic issue_op(input logic [W-1:0] a, input status_t st, input logic [TW-1:0] exp_tag);
      int k;
      req_valid    = 1'b1;
      req_operands = {a, ~a, a};
      req_op       = MUL;
      fpu_in_ready = 1'b1;
      k = 0;
      #1;
      while (!req_ready && k < 20) begin
         tick();
         #1;
         k++;
      end
      checks++;
      if (!req_ready) begin
         failures++;
         $display("FAIL issue_timeout req_ready=%0b required=1", req_ready);
      end else begin
         checks++;
         if (fpu_tag_o !== exp_tag) begin
            failures++;
            $display("FAIL issue_tag actual=%0d required=%0d", fpu_tag_o, exp_tag);
         end
         checks++;
         if (fpu_operands !== {a, ~a, a} || fpu_op !== MUL) begin
            failures++;
            $display("FAIL issue_forward op=%0d required=%0d", fpu_op, MUL);
         end
      end
      fpu_res[exp_tag] = fpu_model(a);
      fpu_st[exp_tag]  = st;
      sb_q.push_back('{result: fpu_model(a), status: st});
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_op    = ADD;
   endtask

   task automatic fpu_return(input logic [TW-1:0] tag);
      fpu_out_valid = 1'b1;
      fpu_tag_i     = tag;
      fpu_result    = fpu_res[tag];
      fpu_status    = fpu_st[tag];
      @(posedge clk);
      #1;
      fpu_out_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++;
      if (req_ready !== 1'b0 || fpu_in_valid !== 1'b0 || fpu_flush !== 1'b0) begin
         failures++;
         $display("FAIL reset_issue req_ready=%0b in_valid=%0b flush=%0b required=0",
                  req_ready, fpu_in_valid, fpu_flush);
      end
      checks++;
      if (rsp_valid !== 1'b0 || rsp_result !== '0 || rsp_status !== '0) begin
         failures++;
         $display("FAIL reset_rsp valid=%0b result=%0h status=%0h required=0",
                  rsp_valid, rsp_result, rsp_status);
      end
      checks++;
      if (busy !== 1'b0 || err_stray !== 1'b0 || fpu_tag_o !== '0) begin
         failures++;
         $display("FAIL reset_state busy=%0b err=%0b tag=%0d required=0", busy, err_stray, fpu_tag_o);
      end
   endtask

   // Fill, out-of-order return 2,0,3,1, retire-while-full, tag wrap.
   task automatic test_order();
      int n;
      do_reset();
      for (int i = 0; i < 4; i++) issue_op(64'h100 + 64'(i), status_t'(5'(i + 1)), TW'(i));
      req_valid    = 1'b1;
      req_operands = {3{64'h200}};
      #1;
      checks++;
      if (req_ready !== 1'b0 || fpu_in_valid !== 1'b0) begin
         failures++;
         $display("FAIL full_block req_ready=%0b in_valid=%0b required=0", req_ready, fpu_in_valid);
      end
      fpu_return(2);
      #1;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
         failures++;
         $display("FAIL tag2_held rsp_valid=%0b req_ready=%0b required=0", rsp_valid, req_ready);
      end
      rsp_ready = 1'b1;
      fpu_return(0);
      #1;
      checks++;
      if (rsp_valid !== 1'b1) begin
         failures++;
         $display("FAIL tag0_latency rsp_valid=%0b required=1", rsp_valid);
      end else begin
         checks++;
         if (rsp_result !== sb_q[0].result || rsp_status !== sb_q[0].status) begin
            failures++;
            $display("FAIL rsp_data actual=%0h/%0h required=%0h/%0h",
                     rsp_result, rsp_status, sb_q[0].result, sb_q[0].status);
         end
         void'(sb_q.pop_front());
      end
      checks++;
      if (req_ready !== 1'b0) begin
         failures++;
         $display("FAIL full_retire_no_bypass req_ready=%0b required=0", req_ready);
      end
      @(posedge clk);
      #1;
      fpu_out_valid = 1'b1;
      fpu_tag_i     = 2'd3;
      fpu_result    = fpu_res[3];
      fpu_status    = fpu_st[3];
      #1;
      checks++;
      if (req_ready !== 1'b1 || fpu_tag_o !== 2'd0) begin
         failures++;
         $display("FAIL wrap_issue req_ready=%0b tag=%0d required=1/0", req_ready, fpu_tag_o);
      end
      checks++;
      if (rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL tag1_not_done rsp_valid=%0b required=0", rsp_valid);
      end
      fpu_res[0] = fpu_model(64'h200);
      fpu_st[0]  = '{nv: 1'b1, dz: 1'b0, of: 1'b0, uf: 1'b0, nx: 1'b0};
      sb_q.push_back('{result: fpu_model(64'h200), status: fpu_st[0]});
      @(posedge clk);
      #1;
      req_valid     = 1'b0;
      fpu_out_valid = 1'b0;
      fpu_return(1);
      n = 3;
      for (int k = 0; k < 40 && n > 0; k++) begin
         #1;
         if (rsp_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
               failures++;
               $display("FAIL order_rsp unexpected result=%0h", rsp_result);
            end else begin
               if (rsp_result !== sb_q[0].result || rsp_status !== sb_q[0].status) begin
                  failures++;
                  $display("FAIL order_rsp actual=%0h/%0h required=%0h/%0h",
                           rsp_result, rsp_status, sb_q[0].result, sb_q[0].status);
               end
               void'(sb_q.pop_front());
            end
            n--;
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (n != 0) begin
         failures++;
         $display("FAIL order_drain_timeout remaining=%0d required=0", n);
      end
      fpu_return(0);
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== sb_q[0].result || rsp_status !== sb_q[0].status) begin
         failures++;
         $display("FAIL wrap_rsp valid=%0b actual=%0h required=%0h", rsp_valid, rsp_result, sb_q[0].result);
      end
      void'(sb_q.pop_front());
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL order_idle busy=%0b rsp_valid=%0b required=0", busy, rsp_valid);
      end
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 3; i++) issue_op(64'h300 + 64'(i), status_t'(5'(i)), TW'(i));
      fpu_return(0);
      flush         = 1'b1;
      rsp_ready     = 1'b1;
      req_valid     = 1'b1;
      fpu_out_valid = 1'b1;
      fpu_tag_i     = 2'd1;
      fpu_result    = fpu_res[1];
      fpu_status    = fpu_st[1];
      #1;
      checks++;
      if (fpu_flush !== 1'b1 || fpu_in_valid !== 1'b0 || req_ready !== 1'b0) begin
         failures++;
         $display("FAIL flush_comb flush=%0b in_valid=%0b req_ready=%0b required=1/0/0",
                  fpu_flush, fpu_in_valid, req_ready);
      end
      @(posedge clk);
      #1;
      flush         = 1'b0;
      req_valid     = 1'b0;
      rsp_ready     = 1'b0;
      fpu_out_valid = 1'b0;
      sb_q.delete();
      #1;
      checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || err_stray !== 1'b0) begin
         failures++;
         $display("FAIL flush_after busy=%0b rsp_valid=%0b err=%0b required=0", busy, rsp_valid, err_stray);
      end
      issue_op(64'h3A0, '{nv: 1'b0, dz: 1'b0, of: 1'b0, uf: 1'b1, nx: 1'b0}, 2'd0);
      fpu_return(0);
      rsp_ready = 1'b1;
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== sb_q[0].result || rsp_status !== sb_q[0].status) begin
         failures++;
         $display("FAIL flush_reissue_rsp valid=%0b actual=%0h required=%0h",
                  rsp_valid, rsp_result, sb_q[0].result);
      end
      void'(sb_q.pop_front());
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_stray();
      int n;
      do_reset();
      issue_op(64'h400, '{nv: 1'b0, dz: 1'b1, of: 1'b0, uf: 1'b0, nx: 1'b0}, 2'd0);
      issue_op(64'h401, '{nv: 1'b0, dz: 1'b0, of: 1'b1, uf: 1'b0, nx: 1'b0}, 2'd1);
      fpu_res[3] = 64'hDEAD_BEEF;
      fpu_st[3]  = '1;
      fpu_return(3);
      #1;
      checks++;
      if (err_stray !== 1'b1 || rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL stray_set err=%0b rsp_valid=%0b required=1/0", err_stray, rsp_valid);
      end
      fpu_return(1);
      fpu_return(0);
      rsp_ready = 1'b1;
      n = 2;
      for (int k = 0; k < 20 && n > 0; k++) begin
         #1;
         if (rsp_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
               failures++;
               $display("FAIL stray_rsp unexpected result=%0h", rsp_result);
            end else begin
               if (rsp_result !== sb_q[0].result || rsp_status !== sb_q[0].status) begin
                  failures++;
                  $display("FAIL stray_rsp actual=%0h/%0h required=%0h/%0h",
                           rsp_result, rsp_status, sb_q[0].result, sb_q[0].status);
               end
               void'(sb_q.pop_front());
            end
            n--;
         end
         @(posedge clk);
         #1;
      end
      rsp_ready = 1'b0;
      #1;
      checks++;
      if (n != 0 || err_stray !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL stray_sticky remaining=%0d err=%0b busy=%0b required=0/1/0", n, err_stray, busy);
      end
      do_reset();
      #1;
      checks++;
      if (err_stray !== 1'b0) begin
         failures++;
         $display("FAIL stray_reset err=%0b required=0", err_stray);
      end
   endtask

`ifdef FPNEW_ISSUE_ROB_FFLAGS_EN
   task automatic test_fflags();
      status_t s_nx, s_of, s_dz;
      s_nx = '{nv: 1'b0, dz: 1'b0, of: 1'b0, uf: 1'b0, nx: 1'b1};
      s_of = '{nv: 1'b0, dz: 1'b0, of: 1'b1, uf: 1'b0, nx: 1'b0};
      s_dz = '{nv: 1'b0, dz: 1'b1, of: 1'b0, uf: 1'b0, nx: 1'b0};
      do_reset();
      #1;
      checks++;
      if (fflags !== '0) begin
         failures++;
         $display("FAIL fflags_reset actual=%0h required=0", fflags);
      end
      issue_op(64'h500, s_nx, 2'd0);
      issue_op(64'h501, s_of, 2'd1);
      issue_op(64'h502, s_dz, 2'd2);
      fpu_return(0);
      fpu_return(1);
      fpu_return(2);
      rsp_ready = 1'b1;
      repeat (2) tick();
      rsp_ready = 1'b0;
      #1;
      checks++;
      if (fflags !== (s_nx | s_of)) begin
         failures++;
         $display("FAIL fflags_accum actual=%0h required=%0h", fflags, s_nx | s_of);
      end
      rsp_ready  = 1'b1;
      fflags_clr = 1'b1;
      tick();
      rsp_ready  = 1'b0;
      fflags_clr = 1'b0;
      #1;
      checks++;
      if (fflags !== s_dz) begin
         failures++;
         $display("FAIL fflags_clr_retire actual=%0h required=%0h", fflags, s_dz);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      checks++;
      if (fflags !== s_dz) begin
         failures++;
         $display("FAIL fflags_flush actual=%0h required=%0h", fflags, s_dz);
      end
      sb_q.delete();
   endtask
`endif

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_order();
      test_flush();
      test_stray();
`ifdef FPNEW_ISSUE_ROB_FFLAGS_EN
      test_fflags();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
